uart_rx: RTL and testbench

//   8N1 UART receiver; companion to uart_tx on the same serial link.

---
 rtl/uart_rx.sv | 172 +++++++++++++++++
 tb/tb_uart_rx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   8N1 UART receiver. It oversamples the asynchronous rx line on clk_50M and
//   recovers each byte by sampling in the middle of every bit. A good byte is
//   presented on rx_data with a one-cycle rx_valid strobe. A low stop bit
//   produces a one-cycle frame_err strobe instead, and the receiver then
//   waits for the line to return high before it looks for another frame.
//
//   Parameters:
//     CLKS_PER_BIT  clk_50M cycles per serial bit (>= 4). Default 434 gives
//                   115200 baud at 50 MHz.
//
//   Ports:
//     clk_50M    in   system clock; all logic on its rising edge
//     rst        in   asynchronous, active-high reset
//     rx         in   serial input, idle high, asynchronous to clk_50M
//     rx_data    out  [7:0] last correctly framed byte (LSB received first)
//     rx_valid   out  one-cycle pulse when rx_data has just been updated
//     frame_err  out  one-cycle pulse when the stop bit was sampled low
//     busy       out  high from start-bit detect until the return to IDLE
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int         HALF_BIT  = CLKS_PER_BIT / 2;
  localparam logic [8:0] HALF_LAST = 9'(HALF_BIT - 1);
  localparam logic [8:0] BIT_LAST  = 9'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       rx_meta;
  logic       rx_s;
  logic [8:0] clk_cnt;
  logic [8:0] clk_cnt_next;
  logic [2:0] bit_idx;
  logic [2:0] bit_idx_next;
  logic [7:0] shreg;
  logic [7:0] shreg_next;
  logic [7:0] rx_data_next;
  logic       rx_valid_next;
  logic       frame_err_next;

  // Two-flop synchroniser. Reset to 1 so that reset looks like an idle line
  // and can never be mistaken for a start bit.
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State and datapath registers. The strobes are registered on the same
  // edge that samples the stop bit, so they are high for exactly the cycle
  // in which the FSM is already back in IDLE (or in BREAK).
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      clk_cnt   <= 9'd0;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      clk_cnt   <= clk_cnt_next;
      bit_idx   <= bit_idx_next;
      shreg     <= shreg_next;
      rx_data   <= rx_data_next;
      rx_valid  <= rx_valid_next;
      frame_err <= frame_err_next;
    end
  end

  // Next-state logic. clk_cnt free-runs inside the timed states and is
  // cleared whenever a sample is taken. START only waits half a bit, which
  // puts every later sample in the middle of its bit. IDLE and BREAK hold
  // the counter at zero so it can never run past CLKS_PER_BIT-1.
  always_comb begin
    state_next     = state;
    clk_cnt_next   = clk_cnt + 9'd1;
    bit_idx_next   = bit_idx;
    shreg_next     = shreg;
    rx_data_next   = rx_data;
    rx_valid_next  = 1'b0;
    frame_err_next = 1'b0;

    case (state)
      IDLE: begin
        clk_cnt_next = 9'd0;
        if (!rx_s) begin
          state_next = START;
        end
      end

      START: begin
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_next = 9'd0;
          if (!rx_s) begin
            state_next   = DATA;
            bit_idx_next = 3'd0;
          end else begin
            state_next = IDLE;
          end
        end
      end

      DATA: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_next        = 9'd0;
          shreg_next[bit_idx] = rx_s;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end
      end

      STOP: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_next = 9'd0;
          if (rx_s) begin
            state_next    = IDLE;
            rx_data_next  = shreg;
            rx_valid_next = 1'b1;
          end else begin
            state_next     = BREAK;
            frame_err_next = 1'b1;
          end
        end
      end

      // A line held low after a framing error must not look like a new
      // start bit, so stay here until it goes high again.
      BREAK: begin
        clk_cnt_next = 9'd0;
        if (rx_s) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next   = IDLE;
        clk_cnt_next = 9'd0;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//   Scoreboard bench for uart_rx. dut0 runs at the default 434 clocks/bit
//   and dut1 runs at 8 clocks/bit. Each frame that is sent pushes its
//   expected outcome into a per-DUT queue. A negedge monitor pops and
//   compares every strobe that a DUT raises.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx0 = 1'b1;
  logic       rx1 = 1'b1;
  logic [7:0] rx_data0;
  logic [7:0] rx_data1;
  logic       v0;
  logic       v1;
  logic       fe0;
  logic       fe1;
  logic       busy0;
  logic       busy1;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    int         exp_cyc;
    int         tol;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_rx dut0 (
    .clk_50M  (clk),
    .rst      (rst),
    .rx       (rx0),
    .rx_data  (rx_data0),
    .rx_valid (v0),
    .frame_err(fe0),
    .busy     (busy0)
  );

  uart_rx #(.CLKS_PER_BIT(8)) dut1 (
    .clk_50M  (clk),
    .rst      (rst),
    .rx       (rx1),
    .rx_data  (rx_data1),
    .rx_valid (v1),
    .frame_err(fe1),
    .busy     (busy1)
  );

  function automatic void checkOutput(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
    end
  endfunction

  // Match one DUT strobe against the oldest expectation for that DUT.
  function automatic void scoreEvent(input int sel, input logic v, input logic fe, input logic [7:0] d);
    exp_t  e;
    int    late;
    string tag;
    tag = (sel == 0) ? "dut0" : "dut1";
    if (v && fe) begin
      checkOutput({tag, "_strobe_overlap"}, int'(v & fe), 0);
    end else if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_unexpected_strobe: got valid=%0b frame_err=%0b data=%h at cycle %0d, required no strobe",
               tag, v, fe, d, cyc);
    end else begin
      if (sel == 0) e = q0.pop_front();
      else          e = q1.pop_front();
      checkOutput({tag, "_strobe_kind"}, int'(fe), int'(e.is_err));
      checkOutput({tag, "_rx_data"}, int'(d), int'(e.data));
      if (e.tol >= 0) begin
        late = cyc - e.exp_cyc;
        checks++;
        if (late < -e.tol || late > e.tol) begin
          errors++;
          $display("[TB] FAIL %s_latency: got strobe at cycle %0d, required %0d +/- %0d",
                   tag, cyc, e.exp_cyc, e.tol);
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (v0 || fe0) scoreEvent(0, v0, fe0, rx_data0);
      if (v1 || fe1) scoreEvent(1, v1, fe1, rx_data1);
    end
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic waitCycle(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic driveBit(input int sel, input logic val);
    int cpb;
    cpb = (sel == 0) ? 434 : 8;
    if (sel == 0) rx0 = val;
    else          rx1 = val;
    repeat (cpb) @(posedge clk);
    #1;
  endtask

  // Send one 8N1 frame and queue its expected outcome. A low stop bit
  // expects a frame_err with rx_data still at its prior value.
  task automatic applyStimulus(input int sel, input logic [7:0] b, input logic stop_bit,
                               input logic [7:0] prior, input int tol);
    exp_t e;
    e.is_err  = !stop_bit;
    e.data    = stop_bit ? b : prior;
    e.exp_cyc = cyc + ((sel == 0) ? 4126 : 79);
    e.tol     = tol;
    if (sel == 0) q0.push_back(e);
    else          q1.push_back(e);
    driveBit(sel, 1'b0);
    for (int i = 0; i < 8; i++) driveBit(sel, b[i]);
    driveBit(sel, stop_bit);
  endtask

  task automatic waitDrain(input int sel, input int budget);
    int n;
    n = 0;
    while (((sel == 0) ? q0.size() : q1.size()) > 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (((sel == 0) ? q0.size() : q1.size()) > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL dut%0d_drain_timeout: got %0d strobes still outstanding, required 0",
               sel, (sel == 0) ? q0.size() : q1.size());
      if (sel == 0) q0.delete();
      else          q1.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion by cycle %0d, required finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         n;
    logic [7:0] b;

    // Reset values
    #1;
    checkOutput("reset_rx_data", int'(rx_data0), 8'h00);
    checkOutput("reset_rx_valid", int'(v0), 0);
    checkOutput("reset_frame_err", int'(fe0), 0);
    checkOutput("reset_busy", int'(busy0), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // 1: single good frame with latency check
    $display("[TB] test 1: 0xDB");
    applyStimulus(0, 8'hDB, 1'b1, 8'h00, 2);
    waitDrain(0, 500);
    checkOutput("t1_rx_data", int'(rx_data0), 8'hDB);

    // 2: 100-cycle glitch is rejected, then a real frame
    $display("[TB] test 2: glitch then 0x3C");
    n   = cyc;
    rx0 = 1'b0;
    waitCycle(n + 50);
    checkOutput("t2_busy_during_glitch", int'(busy0), 1);
    waitCycle(n + 100);
    rx0 = 1'b1;
    waitCycle(n + 220);
    checkOutput("t2_busy_after_glitch", int'(busy0), 0);
    waitCycle(n + 600);
    applyStimulus(0, 8'h3C, 1'b1, 8'hDB, -1);
    waitDrain(0, 500);

    // 3: framing error, held-low line, then recovery
    $display("[TB] test 3: 0x55 bad stop, break, 0x81");
    applyStimulus(0, 8'h55, 1'b0, 8'h3C, -1);
    n = cyc;
    waitCycle(n + 2000);
    checkOutput("t3_busy_in_break", int'(busy0), 1);
    checkOutput("t3_rx_data_kept", int'(rx_data0), 8'h3C);
    rx0 = 1'b1;
    n   = cyc;
    waitCycle(n + 900);
    checkOutput("t3_busy_after_release", int'(busy0), 0);
    applyStimulus(0, 8'h81, 1'b1, 8'h3C, -1);
    waitDrain(0, 500);

    // 4: back-to-back frames with no idle gap
    $display("[TB] test 4: 00 FF A5 back-to-back");
    applyStimulus(0, 8'h00, 1'b1, 8'h81, -1);
    applyStimulus(0, 8'hFF, 1'b1, 8'h00, -1);
    applyStimulus(0, 8'hA5, 1'b1, 8'hFF, -1);
    waitDrain(0, 500);

    // 5: reset during data bit 4 of 0x96
    $display("[TB] test 5: reset mid-frame");
    b = 8'h96;
    driveBit(0, 1'b0);
    for (int i = 0; i < 4; i++) driveBit(0, b[i]);
    rx0 = b[4];
    repeat (217) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("t5_rx_data_in_reset", int'(rx_data0), 8'h00);
    checkOutput("t5_rx_valid_in_reset", int'(v0), 0);
    checkOutput("t5_frame_err_in_reset", int'(fe0), 0);
    checkOutput("t5_busy_in_reset", int'(busy0), 0);
    repeat (3) @(posedge clk);
    #1;
    rx0 = 1'b1;
    rst = 1'b0;
    n   = cyc;
    waitCycle(n + 2000);
    checkOutput("t5_busy_idle_after_reset", int'(busy0), 0);
    applyStimulus(0, 8'h5A, 1'b1, 8'h00, -1);
    waitDrain(0, 500);
    checkOutput("t5_rx_data", int'(rx_data0), 8'h5A);

    // 6: fast instance, exact latency
    $display("[TB] test 6: CLKS_PER_BIT=8, 0xC3");
    applyStimulus(1, 8'hC3, 1'b1, 8'h00, 0);
    waitDrain(1, 100);
    checkOutput("t6_rx_data", int'(rx_data1), 8'hC3);

    repeat (20) @(posedge clk);
    #1;
    waitDrain(0, 10);
    waitDrain(1, 10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
